// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Used by data_mem_resp and dmem_ram.
package dmem_pkg;

  typedef enum logic [1:0] {
    DM_IDLE,
    DM_WAIT,
    DM_RESP
  } dm_state_t;

  localparam int DM_WORD_W = 16;

  // Unsigned offset from base; addresses below base wrap high and fail.
  function automatic logic dm_in_range(
    input logic [15:0] addr,
    input logic [15:0] base,
    input int unsigned depth
  );
    logic [15:0] off;
    off = addr - base;
    return {16'h0000, off} < (depth << 1);
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word RAM: one write port, one synchronous read port.
// A read and write to the same word in one cycle returns the old word.
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int WIDTH = DM_WORD_W,
  parameter int AW    = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/data_mem_resp.sv
// Data-memory responder: one read in flight with wait states, writes every cycle.
// Define DMEM_WR_BYPASS_EN to forward a same-word write at the read capture edge.
module data_mem_resp
  import dmem_pkg::*;
#(
  parameter int          DEPTH       = 256,
  parameter int          WAIT_STATES = 1,
  parameter logic [15:0] BASE_ADDR   = 16'h0200
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] DMAR,
  input  logic        RDV,
  input  logic        DMS,
  input  logic [15:0] DMAW,
  input  logic [15:0] DMO,
  input  logic        WRV,
  output logic [15:0] DMI,
  output logic        DMIE,
  output logic        BUSY,
  output logic        ERR
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  dm_state_t state;
  logic [3:0] cnt;
  logic [AW-1:0] rd_idx;
  logic rd_oor;

  logic [15:0] rdiff;
  logic [15:0] wdiff;
  logic [AW-1:0] req_idx;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] ram_raddr;
  logic req;
  logic req_ok;
  logic wr_ok;
  logic accept;
  logic enter_resp;
  logic dm_unused;
  logic [DM_WORD_W-1:0] ram_q;
  logic [DM_WORD_W-1:0] resp_word;

  assign req     = DMS & RDV;
  assign rdiff   = DMAR - BASE_ADDR;
  assign wdiff   = DMAW - BASE_ADDR;
  assign req_idx = rdiff[AW:1];
  assign wr_idx  = wdiff[AW:1];
  assign req_ok  = dm_in_range(DMAR, BASE_ADDR, DEPTH);
  assign wr_ok   = dm_in_range(DMAW, BASE_ADDR, DEPTH);
  assign dm_unused = ^{rdiff, wdiff};

  assign accept =
    req & ((state == DM_IDLE) | (state == DM_RESP));

  // RAM is read on the edge that moves the FSM into RESP.
  assign enter_resp =
    (accept & (WS == 4'd0)) |
    ((state == DM_WAIT) & (cnt == 4'd1));

  assign ram_raddr =
    (state == DM_WAIT) ? rd_idx : req_idx;

  assign BUSY =
    (state == DM_WAIT) |
    ((state == DM_RESP) & ~req);

  dmem_ram #(
    .DEPTH(DEPTH),
    .WIDTH(DM_WORD_W),
    .AW   (AW)
  ) u_ram (
    .clk  (CLK),
    .we   (WRV & wr_ok),
    .waddr(wr_idx),
    .wdata(DMO),
    .re   (enter_resp),
    .raddr(ram_raddr),
    .rdata(ram_q)
  );

`ifdef DMEM_WR_BYPASS_EN
  logic byp_hit;
  logic [DM_WORD_W-1:0] byp_data;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      byp_hit  <= 1'b0;
      byp_data <= '0;
    end else if (enter_resp) begin
      byp_hit  <= WRV & wr_ok & (wr_idx == ram_raddr);
      byp_data <= DMO;
    end
  end

  assign resp_word = byp_hit ? byp_data : ram_q;
`else
  assign resp_word = ram_q;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= DM_IDLE;
      cnt    <= 4'd0;
      rd_idx <= '0;
      rd_oor <= 1'b0;
      DMI    <= '0;
      DMIE   <= 1'b0;
      ERR    <= 1'b0;
    end else begin
      DMIE <= 1'b0;
      if ((WRV & ~wr_ok) | (accept & ~req_ok)) begin
        ERR <= 1'b1;
      end
      if (accept) begin
        rd_idx <= req_idx;
        rd_oor <= ~req_ok;
      end
      if (state == DM_RESP) begin
        DMIE <= 1'b1;
        DMI  <= rd_oor ? '0 : resp_word;
      end
      unique case (state)
        DM_IDLE, DM_RESP: begin
          if (!accept) begin
            state <= DM_IDLE;
          end else if (WS == 4'd0) begin
            state <= DM_RESP;
          end else begin
            state <= DM_WAIT;
            cnt   <= WS;
          end
        end
        DM_WAIT: begin
          if (cnt == 4'd1) begin
            state <= DM_RESP;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= DM_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// Scoreboard bench for data_mem_resp: WAIT_STATES=1 and WAIT_STATES=0 instances.
module tb_data_mem_resp;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

`ifdef DMEM_WR_BYPASS_EN
  localparam logic [15:0] CAP_EXP = 16'h1234;
`else
  localparam logic [15:0] CAP_EXP = 16'h5555;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  logic [15:0] a_dmar = '0, a_dmaw = '0, a_dmo = '0;
  logic a_rdv = 1'b0, a_dms = 1'b0, a_wrv = 1'b0;
  logic [15:0] a_dmi;
  logic a_dmie, a_busy, a_err;

  logic [15:0] b_dmar = '0, b_dmaw = '0, b_dmo = '0;
  logic b_rdv = 1'b0, b_dms = 1'b0, b_wrv = 1'b0;
  logic [15:0] b_dmi;
  logic b_dmie, b_busy, b_err;

  exp_t qa[$];
  exp_t qb[$];
  exp_t xa, xb;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_resp #(
    .DEPTH(256), .WAIT_STATES(1), .BASE_ADDR(16'h0200)
  ) u_dut (
    .CLK(clk), .RST_N(rst_n),
    .DMAR(a_dmar), .RDV(a_rdv), .DMS(a_dms),
    .DMAW(a_dmaw), .DMO(a_dmo), .WRV(a_wrv),
    .DMI(a_dmi), .DMIE(a_dmie), .BUSY(a_busy), .ERR(a_err)
  );

  data_mem_resp #(
    .DEPTH(256), .WAIT_STATES(0), .BASE_ADDR(16'h0200)
  ) u_dut0 (
    .CLK(clk), .RST_N(rst_n),
    .DMAR(b_dmar), .RDV(b_rdv), .DMS(b_dms),
    .DMAW(b_dmaw), .DMO(b_dmo), .WRV(b_wrv),
    .DMI(b_dmi), .DMIE(b_dmie), .BUSY(b_busy), .ERR(b_err)
  );

  task automatic chk(input string name, input logic [15:0] got,
                     input logic [15:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic tick(output int e);
    @(posedge clk);
    #1;
    e = cyc;
  endtask

  task automatic wr_a(input logic [15:0] addr, input logic [15:0] d);
    int e;
    a_wrv = 1'b1; a_dmaw = addr; a_dmo = d;
    tick(e);
    a_wrv = 1'b0;
  endtask

  task automatic wr_b(input logic [15:0] addr, input logic [15:0] d);
    int e;
    b_wrv = 1'b1; b_dmaw = addr; b_dmo = d;
    tick(e);
    b_wrv = 1'b0;
  endtask

  task automatic rd_a(input logic [15:0] addr, input logic [15:0] d);
    int e;
    a_dms = 1'b1; a_rdv = 1'b1; a_dmar = addr;
    tick(e);
    qa.push_back('{d, e + 2});
    a_dms = 1'b0; a_rdv = 1'b0;
    repeat (3) tick(e);
  endtask

  always @(negedge clk) begin
    if (a_dmie) begin
      checks++;
      if (qa.size() == 0) begin
        failures++;
        $display("FAIL a_unexpected_dmie cyc=%0d dmi=%h", cyc, a_dmi);
      end else begin
        xa = qa.pop_front();
        if (a_dmi !== xa.data || cyc != xa.cyc) begin
          failures++;
          $display("FAIL a_resp got=%h@%0d want=%h@%0d",
                   a_dmi, cyc, xa.data, xa.cyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (b_dmie) begin
      checks++;
      if (qb.size() == 0) begin
        failures++;
        $display("FAIL b_unexpected_dmie cyc=%0d dmi=%h", cyc, b_dmi);
      end else begin
        xb = qb.pop_front();
        if (b_dmi !== xb.data || cyc != xb.cyc) begin
          failures++;
          $display("FAIL b_resp got=%h@%0d want=%h@%0d",
                   b_dmi, cyc, xb.data, xb.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int e;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_dmi", a_dmi, 16'h0000);
    chk("rst_dmie", 16'(a_dmie), 16'h0);
    chk("rst_busy", 16'(a_busy), 16'h0);
    chk("rst_err", 16'(a_err), 16'h0);
    chk("rst_b_busy", 16'(b_busy), 16'h0);
    tick(e);
    rst_n = 1'b1;
    tick(e);

    // write then read back with one wait state
    wr_a(16'h0204, 16'hBEEF);
    a_dms = 1'b1; a_rdv = 1'b1; a_dmar = 16'h0204;
    tick(e);
    qa.push_back('{16'hBEEF, e + 2});
    a_dms = 1'b0; a_rdv = 1'b0;
    @(negedge clk);
    chk("busy_wait", 16'(a_busy), 16'h1);
    repeat (4) tick(e);

    // back-to-back: second request held until RESP
    wr_a(16'h0200, 16'h1111);
    wr_a(16'h0202, 16'h2222);
    a_dms = 1'b1; a_rdv = 1'b1; a_dmar = 16'h0200;
    tick(e);
    qa.push_back('{16'h1111, e + 2});
    a_dmar = 16'h0202;
    @(negedge clk);
    chk("b2b_busy_wait", 16'(a_busy), 16'h1);
    tick(e);
    @(negedge clk);
    chk("b2b_busy_resp", 16'(a_busy), 16'h0);
    tick(e);
    qa.push_back('{16'h2222, e + 2});
    a_dms = 1'b0; a_rdv = 1'b0;
    repeat (4) tick(e);

    // out of range write and read
    @(negedge clk);
    chk("err_before", 16'(a_err), 16'h0);
    wr_a(16'h0400, 16'hABCD);
    @(negedge clk);
    chk("err_oor_wr", 16'(a_err), 16'h1);
    rd_a(16'h0100, 16'h0000);
    rd_a(16'h0200, 16'h1111);

    // write landing on the read capture edge
    wr_a(16'h0206, 16'h5555);
    a_dms = 1'b1; a_rdv = 1'b1; a_dmar = 16'h0206;
    tick(e);
    a_dms = 1'b0; a_rdv = 1'b0;
    a_wrv = 1'b1; a_dmaw = 16'h0206; a_dmo = 16'h1234;
    qa.push_back('{CAP_EXP, e + 2});
    tick(e);
    a_wrv = 1'b0;
    repeat (3) tick(e);
    rd_a(16'h0206, 16'h1234);
    @(negedge clk);
    chk("err_sticky", 16'(a_err), 16'h1);

    // reset in the middle of a wait state
    a_dms = 1'b1; a_rdv = 1'b1; a_dmar = 16'h0200;
    tick(e);
    a_dms = 1'b0; a_rdv = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_dmi", a_dmi, 16'h0000);
    chk("midrst_dmie", 16'(a_dmie), 16'h0);
    chk("midrst_busy", 16'(a_busy), 16'h0);
    chk("midrst_err", 16'(a_err), 16'h0);
    repeat (2) tick(e);
    rst_n = 1'b1;
    repeat (5) tick(e);

    // zero wait states, continuous requests
    wr_b(16'h0200, 16'h0A0A);
    wr_b(16'h0202, 16'h0B0B);
    wr_b(16'h0204, 16'h0C0C);
    b_dms = 1'b1; b_rdv = 1'b1; b_dmar = 16'h0200;
    tick(e);
    qb.push_back('{16'h0A0A, e + 1});
    b_dmar = 16'h0202;
    @(negedge clk);
    chk("ws0_busy1", 16'(b_busy), 16'h0);
    tick(e);
    qb.push_back('{16'h0B0B, e + 1});
    b_dmar = 16'h0204;
    @(negedge clk);
    chk("ws0_busy2", 16'(b_busy), 16'h0);
    tick(e);
    qb.push_back('{16'h0C0C, e + 1});
    b_dms = 1'b0; b_rdv = 1'b0;
    repeat (5) tick(e);

    chk("a_queue_empty", 16'(qa.size()), 16'h0);
    chk("b_queue_empty", 16'(qb.size()), 16'h0);
    chk("b_err_end", 16'(b_err), 16'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
